fp16_result_normalizer: RTL and testbench

//  Post-arithmetic normalizer for the half-precision FP add/sub unit (1/5/10 format).

---
 rtl/fp16_pkg.sv | 25 ++
 rtl/fp16_result_normalizer_if.sv | 33 +++
 rtl/fp16_exp_step.sv | 31 +++
 rtl/fp16_result_normalizer.sv | 146 ++++++++++++++
 tb/tb_fp16_result_normalizer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the add/sub result normalizer: field widths,
// normalizer FSM states and the packed sign/exponent/fraction record.
package fp16_pkg;

    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int EXP_MAX = 31;
    localparam int BIAS    = 15;

    localparam logic [EXP_W-1:0] EXP_SAT = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } norm_state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp16_t;

endpackage

// File: rtl/fp16_result_normalizer_if.sv
// Operand-in / result-out handshake bundle of the FP16 result normalizer.
// master = upstream datapath plus writeback consumer, slave = the normalizer.
interface fp16_result_normalizer_if;
    import fp16_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [MAN_W+1:0] in_man;

    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [EXP_W-1:0] out_exp;
    logic [MAN_W-1:0] out_man;
    logic [3:0]       out_shift;
    logic             out_overflow;
    logic             out_underflow;

    modport master (
        output in_valid, in_sign, in_exp, in_man, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_man,
               out_shift, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_man, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_man,
               out_shift, out_overflow, out_underflow
    );

endinterface

// File: rtl/fp16_exp_step.sv
// Saturating 5-bit exponent increment/decrement from a half-adder ripple chain.
// dir=1 increments, dir=0 decrements; at_limit flags a result of 31 (inc) or 1 (dec).
module fp16_exp_step
    import fp16_pkg::*;
(
    input  logic [EXP_W-1:0] exp,
    input  logic             dir,
    output logic [EXP_W-1:0] exp_next,
    output logic             at_limit
);

    logic [EXP_W-1:0] opnd;
    logic [EXP_W-1:0] sum;
    logic [EXP_W:0]   carry;

    // Decrement is ~(~exp + 1), so one incrementer chain serves both directions.
    assign opnd     = dir ? exp : ~exp;
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < EXP_W; gi++) begin : g_half_add
            assign sum[gi]     = opnd[gi] ^ carry[gi];
            assign carry[gi+1] = opnd[gi] & carry[gi];
        end
    endgenerate

    // A carry out of the chain means 31+1 or 0-1: hold the input instead of wrapping.
    assign exp_next = carry[EXP_W] ? exp : (dir ? sum : ~sum);
    assign at_limit = dir ? (exp_next == EXP_SAT) : (exp_next == EXP_ONE);

endmodule

// File: rtl/fp16_result_normalizer.sv
// FP16 post-add normalizer: one left shift per cycle, packed result held until accepted.
// Build option FP16_NORM_DENORM_EN: keep subnormal fractions instead of flushing to zero.
module fp16_result_normalizer
    import fp16_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    fp16_result_normalizer_if.slave  bus
);

`ifdef FP16_NORM_DENORM_EN
    localparam bit DENORM_EN = 1'b1;
`else
    localparam bit DENORM_EN = 1'b0;
`endif

    norm_state_t      state_reg, state_next;
    logic [MAN_W-1:0] man_reg, man_next;
    logic [EXP_W-1:0] exp_reg, exp_next;
    logic [3:0]       shift_reg, shift_next;
    fp16_t            res_reg, res_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;

    logic [EXP_W-1:0] eff_exp;
    logic [MAN_W:0]   man_sh;
    logic [EXP_W-1:0] step_in;
    logic [EXP_W-1:0] step_out;
    logic             step_dir;
    logic             step_limit;

    // A zero exponent with a nonzero mantissa is subnormal and scales like exponent 1.
    assign eff_exp  = (bus.in_exp == '0) ? EXP_ONE : bus.in_exp;
    // Only the fraction is kept while shifting; bit MAN_W of man_sh is the new hidden bit.
    assign man_sh   = {man_reg, 1'b0};

    assign step_dir = (state_reg == IDLE);
    assign step_in  = (state_reg == IDLE) ? eff_exp : exp_reg;

    fp16_exp_step u_exp_step (
        .exp      (step_in),
        .dir      (step_dir),
        .exp_next (step_out),
        .at_limit (step_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            man_reg   <= '0;
            exp_reg   <= '0;
            shift_reg <= '0;
            res_reg   <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            man_reg   <= man_next;
            exp_reg   <= exp_next;
            shift_reg <= shift_next;
            res_reg   <= res_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        man_next   = man_reg;
        exp_next   = exp_reg;
        shift_next = shift_reg;
        res_next   = res_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    res_next.sign = bus.in_sign;
                    shift_next    = '0;
                    ovf_next      = 1'b0;
                    unf_next      = 1'b0;
                    state_next    = DONE;
                    if (bus.in_man == '0) begin
                        res_next.exp = '0;
                        res_next.man = '0;
                    end else if (bus.in_man[MAN_W+1]) begin
                        if (step_limit) begin
                            res_next.exp = EXP_SAT;
                            res_next.man = '0;
                            ovf_next     = 1'b1;
                        end else begin
                            res_next.exp = step_out;
                            res_next.man = bus.in_man[MAN_W:1];
                        end
                    end else if (bus.in_man[MAN_W]) begin
                        res_next.exp = eff_exp;
                        res_next.man = bus.in_man[MAN_W-1:0];
                    end else if (eff_exp == EXP_ONE) begin
                        // No room to shift left: already subnormal.
                        res_next.exp = '0;
                        res_next.man = DENORM_EN ? bus.in_man[MAN_W-1:0] : '0;
                        unf_next     = 1'b1;
                    end else begin
                        man_next   = bus.in_man[MAN_W-1:0];
                        exp_next   = eff_exp;
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                man_next   = man_sh[MAN_W-1:0];
                exp_next   = step_out;
                shift_next = shift_reg + 4'd1;
                if (man_sh[MAN_W]) begin
                    res_next.exp = step_out;
                    res_next.man = man_sh[MAN_W-1:0];
                    state_next   = DONE;
                end else if (step_limit) begin
                    res_next.exp = '0;
                    res_next.man = DENORM_EN ? man_sh[MAN_W-1:0] : '0;
                    unf_next     = 1'b1;
                    state_next   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready      = (state_reg == IDLE);
    assign bus.out_valid     = (state_reg == DONE);
    assign bus.out_sign      = res_reg.sign;
    assign bus.out_exp       = res_reg.exp;
    assign bus.out_man       = res_reg.man;
    assign bus.out_shift     = shift_reg;
    assign bus.out_overflow  = ovf_reg;
    assign bus.out_underflow = unf_reg;

endmodule

// File: tb/tb_fp16_result_normalizer.sv
// Directed and random checks of fp16_result_normalizer against a leading-zero based
// reference model; honours FP16_NORM_DENORM_EN the same way as the design.
module tb_fp16_result_normalizer;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] man;
        logic [3:0] shift;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fp16_result_normalizer_if bus ();

    fp16_result_normalizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic s, input int e, input int m, input int sh,
                                input logic o, input logic u);
        exp_t r;
        r.sign  = s;
        r.exp   = 5'(e);
        r.man   = 10'(m);
        r.shift = 4'(sh);
        r.ovf   = o;
        r.unf   = u;
        return r;
    endfunction

    // Reference: locate the leading one, then clip the shift at the exponent floor.
    function automatic exp_t model(input logic s, input logic [4:0] e, input logic [11:0] m);
        exp_t        r;
        int          ee;
        int          msb;
        int          k;
        logic [11:0] t;
        r      = '0;
        r.sign = s;
        ee     = (e == 5'd0) ? 1 : int'(e);
        if (m == 12'd0) return r;
        if (m[11]) begin
            ee = ee + 1;
            if (ee >= 31) begin
                r.exp = 5'd31;
                r.ovf = 1'b1;
            end else begin
                r.exp = 5'(ee);
                r.man = m[10:1];
            end
            return r;
        end
        msb = 0;
        for (int b = 0; b <= 10; b++) if (m[b]) msb = b;
        k = 10 - msb;
        if (ee - k < 1) begin
            k     = ee - 1;
            t     = m << k;
            r.exp = 5'd0;
            r.unf = 1'b1;
`ifdef FP16_NORM_DENORM_EN
            r.man = t[9:0];
`else
            r.man = 10'd0;
`endif
        end else begin
            t     = m << k;
            r.exp = 5'(ee - k);
            r.man = t[9:0];
        end
        r.shift = 4'(k);
        return r;
    endfunction

    task automatic check_result(input string tag, input exp_t x);
        chk({tag, ".sign"}, 32'(bus.out_sign), 32'(x.sign));
        chk({tag, ".exp"}, 32'(bus.out_exp), 32'(x.exp));
        chk({tag, ".man"}, 32'(bus.out_man), 32'(x.man));
        chk({tag, ".shift"}, 32'(bus.out_shift), 32'(x.shift));
        chk({tag, ".ovf"}, 32'(bus.out_overflow), 32'(x.ovf));
        chk({tag, ".unf"}, 32'(bus.out_underflow), 32'(x.unf));
    endtask

    // One operand through the normalizer: handshake, latency, fields, hold, accept.
    task automatic run(input string tag, input logic s, input logic [4:0] e,
                       input logic [11:0] m, input exp_t x, input int hold);
        int c;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_man   = m;
        chk({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        c = 1;
        if (x.shift != 0) chk({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        while (bus.out_valid !== 1'b1 && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk({tag, ".latency"}, 32'(c), 32'(1 + int'(x.shift)));
        check_result(tag, x);
        for (int h = 0; h < hold; h++) begin
            // A new operand offered while busy must be ignored.
            bus.in_valid = 1'b1;
            bus.in_man   = 12'($urandom_range(0, 4095));
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            chk({tag, ".hold_exp"}, 32'(bus.out_exp), 32'(x.exp));
            chk({tag, ".hold_man"}, 32'(bus.out_man), 32'(x.man));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, ".accept_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".accept_in_ready"}, 32'(bus.in_ready), 32'd1);
        $display("txn %s: sign=%0d exp=%0d man=%03h -> exp=%0d man=%03h shift=%0d ovf=%0d unf=%0d lat=%0d",
                 tag, s, e, m, bus.out_exp, bus.out_man, bus.out_shift,
                 bus.out_overflow, bus.out_underflow, c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s;
        logic [4:0]  e;
        logic [11:0] m;
        exp_t        x;

        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_man    = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
        check_result("reset", mk(0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        run("t1_aligned", 1'b0, 5'd15, 12'h400, mk(0, 15, 0, 0, 0, 0), 0);
        run("t2_max_shift", 1'b0, 5'd15, 12'h001, mk(0, 5, 0, 10, 0, 0), 0);
        run("t3_carry", 1'b0, 5'd14, 12'hC00, mk(0, 15, 10'h200, 0, 0, 0), 0);
        run("t3_overflow", 1'b1, 5'd30, 12'h800, mk(1, 31, 0, 0, 1, 0), 0);
`ifdef FP16_NORM_DENORM_EN
        run("t4_underflow", 1'b0, 5'd3, 12'h020, mk(0, 0, 10'h080, 2, 0, 1), 0);
        run("t4_subnormal_in", 1'b1, 5'd0, 12'h155, mk(1, 0, 10'h155, 0, 0, 1), 0);
`else
        run("t4_underflow", 1'b0, 5'd3, 12'h020, mk(0, 0, 0, 2, 0, 1), 0);
        run("t4_subnormal_in", 1'b1, 5'd0, 12'h155, mk(1, 0, 0, 0, 0, 1), 0);
`endif
        run("t5_zero", 1'b1, 5'd9, 12'h000, mk(1, 0, 0, 0, 0, 0), 0);
        run("t6_backpressure", 1'b0, 5'd20, 12'h3FF, mk(0, 19, 10'h3FE, 1, 0, 0), 3);

        // Reset during the fourth SHIFT cycle drops the in-flight result.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b1;
        bus.in_exp   = 5'd15;
        bus.in_man   = 12'h001;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rst_mid.busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid.in_ready", 32'(bus.in_ready), 32'd1);
        check_result("rst_mid", mk(0, 0, 0, 0, 0, 0));
        $display("txn rst_mid: reset in SHIFT, out_valid=%0d in_ready=%0d", bus.out_valid, bus.in_ready);

        run("after_rst", 1'b0, 5'd15, 12'h400, mk(0, 15, 0, 0, 0, 0), 0);

        for (int i = 0; i < 60; i++) begin
            s = 1'($urandom_range(0, 1));
            e = 5'($urandom_range(1, 30));
            m = 12'($urandom_range(0, 4095) >> $urandom_range(0, 11));
            if (i % 8 == 7) begin
                e = 5'd0;
                m = m & 12'h3FF;
            end
            x = model(s, e, m);
            run($sformatf("rand%0d", i), s, e, m, x, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
